// File: rtl/weight_bram_arbiter_pkg.sv
// rtl/weight_bram_arbiter_pkg.sv - shared constants and FSM encoding for the weight BRAM arbiter
//
// Purpose: default geometry of the shared weight BRAM port (requester count,
//          word width, address/length widths, read latency), the burst FSM
//          state encoding, and a helper that sizes requester index fields.
// Ports:   none (package).

package weight_bram_arbiter_pkg;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_W          = 8;
  localparam int DEF_ADDR_WIDTH = 18;
  localparam int DEF_LEN_WIDTH  = 19;
  localparam int DEF_RD_LAT     = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // A single requester still needs a 1-bit index field.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_bram_arbiter_rr_arbiter.sv
// rtl/weight_bram_arbiter_rr_arbiter.sv - round-robin winner selection for the weight BRAM
//
// Purpose: picks one requester, searching from the index after the last
//          granted one and wrapping, so every requester is served in turn.
// Ports:
//   i_req    [N_REQ]  request levels
//   i_last   [IDXW]   index of the most recently granted requester
//   o_winner [N_REQ]  one-hot winner, all zero when nobody requests

module rr_arbiter
  import weight_bram_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDXW  = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDXW-1:0]  i_last,
  output logic [N_REQ-1:0] o_winner
);

  logic [IDXW-1:0] w_sel;
  logic            w_found;

  // Offset 1 is checked first and offset N_REQ (the last owner itself) last.
  always_comb begin
    o_winner = '0;
    w_found  = 1'b0;
    w_sel    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      w_sel = IDXW'((int'(i_last) + i) % N_REQ);
      if (!w_found && i_req[w_sel]) begin
        o_winner[w_sel] = 1'b1;
        w_found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/weight_bram_arbiter.sv
// rtl/weight_bram_arbiter.sv - burst arbiter sharing one weight BRAM read port among loaders
//
// Purpose: grants the BRAM to one weight-loader at a time for a whole burst,
//          streams len consecutive addresses, returns the read data tagged to
//          the owner, then pulses done and re-arbitrates round-robin.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_req       [N_REQ]     burst request levels, held until grant
//   i_base_addr [N_REQ*AW]  per-requester burst start address
//   i_len       [N_REQ*LW]  per-requester burst length in words
//   o_grant     [N_REQ]     one-hot owner for the whole burst incl. drain
//   o_rd_valid  [N_REQ]     one-hot tag for o_rd_data
//   o_rd_data   [W]         read word (straight from i_bram_dout)
//   o_done      [N_REQ]     one-cycle end-of-burst pulse
//   o_bram_en, o_bram_ren   BRAM enable / read enable
//   o_bram_addr [AW]        BRAM address
//   i_bram_dout [W]         BRAM read data

module weight_bram_arbiter
  import weight_bram_arbiter_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int W          = DEF_W,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int RD_LAT     = DEF_RD_LAT
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [N_REQ-1:0]              i_req,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   i_base_addr,
  input  logic [N_REQ*LEN_WIDTH-1:0]    i_len,
  output logic [N_REQ-1:0]              o_grant,
  output logic [N_REQ-1:0]              o_rd_valid,
  output logic [W-1:0]                  o_rd_data,
  output logic [N_REQ-1:0]              o_done,
  output logic                          o_bram_en,
  output logic                          o_bram_ren,
  output logic [ADDR_WIDTH-1:0]         o_bram_addr,
  input  logic [W-1:0]                  i_bram_dout
);

  localparam int IDXW = idx_width(N_REQ);

  state_t                r_state;
  state_t                w_state_next;
  logic [IDXW-1:0]       r_owner;
  logic [IDXW-1:0]       r_last;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic [RD_LAT-1:0]     r_vld_sr;
  logic [IDXW-1:0]       r_own_sr [RD_LAT];

  logic [N_REQ-1:0]      w_winner;
  logic [IDXW-1:0]       w_win_idx;
  logic [ADDR_WIDTH-1:0] w_win_base;
  logic [LEN_WIDTH-1:0]  w_win_len;
  logic                  w_any_req;
  logic                  w_issue;
  logic                  w_last_issue;
  logic [RD_LAT-1:0]     w_vld_shift;
  logic                  w_in_flight;
  logic [N_REQ-1:0]      w_owner_oh;
  logic [N_REQ-1:0]      w_rd_owner_oh;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDXW  (IDXW)
  ) u_rr_arbiter (
    .i_req    (i_req),
    .i_last   (r_last),
    .o_winner (w_winner)
  );

  // Winner index plus its burst descriptor, muxed from the flat input buses.
  always_comb begin
    w_win_idx  = '0;
    w_win_base = '0;
    w_win_len  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_winner[i]) begin
        w_win_idx  = IDXW'(i);
        w_win_base = i_base_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_win_len  = i_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  assign w_any_req    = |i_req;
  assign w_issue      = (r_state == ST_ISSUE);
  assign w_last_issue = ((r_cnt + LEN_WIDTH'(1)) == r_len);
  // Valid bits still in flight behind the one currently at the output stage.
  assign w_vld_shift  = r_vld_sr << 1;
  assign w_in_flight  = |r_vld_sr;
  assign w_owner_oh    = N_REQ'(1) << r_owner;
  assign w_rd_owner_oh = N_REQ'(1) << r_own_sr[RD_LAT-1];

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. A zero-length burst goes straight to DRAIN with an empty
  // pipeline: that single cycle carries the grant and DRAIN exits at once.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_next = (w_win_len == '0) ? ST_DRAIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (w_last_issue) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_vld_shift == '0) begin
          w_state_next = ST_FINISH;
        end
      end
      ST_FINISH: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Burst descriptor, address counter and read-valid alignment pipeline.
  // r_last resets to the top index so requester 0 is searched first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_owner  <= '0;
      r_last   <= IDXW'(N_REQ - 1);
      r_base   <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_vld_sr <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_own_sr[i] <= '0;
      end
    end else begin
      if (r_state == ST_IDLE && w_any_req) begin
        r_owner <= w_win_idx;
        r_last  <= w_win_idx;
        r_base  <= w_win_base;
        r_len   <= w_win_len;
        r_cnt   <= '0;
      end else if (w_issue) begin
        r_cnt <= r_cnt + LEN_WIDTH'(1);
      end
      r_vld_sr    <= (r_vld_sr << 1) | RD_LAT'(w_issue);
      r_own_sr[0] <= r_owner;
      for (int i = 1; i < RD_LAT; i++) begin
        r_own_sr[i] <= r_own_sr[i-1];
      end
    end
  end

  // Outputs. Forced to zero while reset is held so an aborted burst shows
  // nothing, not even in the cycle reset is first applied.
  always_comb begin
    o_grant     = '0;
    o_rd_valid  = '0;
    o_done      = '0;
    o_bram_en   = 1'b0;
    o_bram_ren  = 1'b0;
    o_bram_addr = '0;
    if (!i_rst) begin
      case (r_state)
        ST_ISSUE: begin
          o_grant     = w_owner_oh;
          o_bram_en   = 1'b1;
          o_bram_ren  = 1'b1;
          o_bram_addr = r_base + ADDR_WIDTH'(r_cnt);
        end
        ST_DRAIN: begin
          o_grant   = w_owner_oh;
          o_bram_en = w_in_flight;
        end
        ST_FINISH: begin
          o_done = w_owner_oh;
        end
        default: begin
        end
      endcase
      if (r_vld_sr[RD_LAT-1]) begin
        o_rd_valid = w_rd_owner_oh;
      end
    end
  end

  assign o_rd_data = i_bram_dout;

endmodule
